// File: rtl/arb_pkg.sv
// Shared definitions for the packet output arbiter: FSM states, header magic
// and parameter defaults. HEADER state exists only with PKT_OUTPUT_ARBITER_HEADER_EN.
package arb_pkg;

`ifdef PKT_OUTPUT_ARBITER_HEADER_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_XFER   = 2'd2
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd2
  } arb_state_e;
`endif

  localparam logic [7:0] HDR_MAGIC         = 8'hA5;
  localparam int         DEF_N_UNITS       = 4;
  localparam int         DEF_MAX_PKT_WORDS = 256;

endpackage

// File: rtl/pkt_output_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_idx, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [IW-1:0] win_idx,
  output logic          found
);

  int idx;

  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_idx) + k) % N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/pkt_output_arbiter.sv
// Round-robin packet arbiter merging N_UNITS word streams into one output FIFO.
// Optional per-packet header word when PKT_OUTPUT_ARBITER_HEADER_EN is defined.
module pkt_output_arbiter
  import arb_pkg::*;
#(
  parameter int N_UNITS       = DEF_N_UNITS,
  parameter int MAX_PKT_WORDS = DEF_MAX_PKT_WORDS
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        en,
  input  logic [N_UNITS*64-1:0]       unit_dout,
  input  logic [N_UNITS-1:0]          unit_valid,
  input  logic [N_UNITS-1:0]          unit_last,
  output logic [N_UNITS-1:0]          unit_rd_en,
  output logic [63:0]                 dout,
  output logic                        wr_en,
  input  logic                        full,
  output logic                        pkt_end,
  output logic [$clog2(N_UNITS)-1:0]  grant_id,
  output logic                        busy,
  output logic [15:0]                 pkt_count,
  output logic [1:0]                  dbg_state
);

  localparam int IW  = $clog2(N_UNITS);
  localparam int WCW = (MAX_PKT_WORDS > 1) ? $clog2(MAX_PKT_WORDS) : 1;

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [IW-1:0]  last_grant_q, last_grant_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [15:0]    pkt_count_q, pkt_count_d;

  logic [IW-1:0]  pick_idx;
  logic           pick_found;
  logic           sel_valid;
  logic           sel_last;
  logic [63:0]    sel_word;
  logic           accept;
  logic           end_word;

  rr_pick #(.N(N_UNITS), .IW(IW)) u_rr_pick (
    .req      (unit_valid),
    .last_idx (last_grant_q),
    .win_idx  (pick_idx),
    .found    (pick_found)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(N_UNITS - 1);
      word_cnt_q   <= '0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_word  = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (grant_q == IW'(i)) begin
        sel_valid = unit_valid[i];
        sel_last  = unit_last[i];
        sel_word  = unit_dout[64*i +: 64];
      end
    end

    // Zero-latency path: the granted unit's word goes straight to the FIFO.
    accept   = (state_q == ST_XFER) && sel_valid && !full;
    end_word = sel_last || (word_cnt_q == WCW'(MAX_PKT_WORDS - 1));
    pkt_end  = accept && end_word;
    wr_en    = accept;
    dout     = accept ? sel_word : 64'h0;
    for (int i = 0; i < N_UNITS; i++) begin
      unit_rd_en[i] = accept && (grant_q == IW'(i));
    end

    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    pkt_count_d  = pkt_count_q;

    case (state_q)
      ST_IDLE: begin
        if (en && pick_found) begin
          grant_d    = pick_idx;
          word_cnt_d = '0;
`ifdef PKT_OUTPUT_ARBITER_HEADER_EN
          state_d    = ST_HEADER;
`else
          state_d    = ST_XFER;
`endif
        end
      end
`ifdef PKT_OUTPUT_ARBITER_HEADER_EN
      ST_HEADER: begin
        if (!full) begin
          wr_en      = 1'b1;
          dout       = {HDR_MAGIC, 8'(grant_q), pkt_count_q, 32'h0};
          word_cnt_d = '0;
          state_d    = ST_XFER;
        end
      end
`endif
      ST_XFER: begin
        if (accept) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (end_word) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_q;
            pkt_count_d  = pkt_count_q + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign pkt_count = pkt_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pkt_output_arbiter.sv
// Randomised and directed bench for pkt_output_arbiter against a per-cycle
// behavioural model driven by per-unit packet queues.
module tb_pkt_output_arbiter;
  localparam int N    = 4;
  localparam int MAXW = 256;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            en;
  logic [N*64-1:0] unit_dout;
  logic [N-1:0]    unit_valid;
  logic [N-1:0]    unit_last;
  logic [N-1:0]    unit_rd_en;
  logic [63:0]     dout;
  logic            wr_en;
  logic            full;
  logic            pkt_end;
  logic [1:0]      grant_id;
  logic            busy;
  logic [15:0]     pkt_count;
  logic [1:0]      dbg_state;

  pkt_output_arbiter #(.N_UNITS(N), .MAX_PKT_WORDS(MAXW)) dut (
    .CLK(CLK), .RESET(RESET), .en(en), .unit_dout(unit_dout),
    .unit_valid(unit_valid), .unit_last(unit_last), .unit_rd_en(unit_rd_en),
    .dout(dout), .wr_en(wr_en), .full(full), .pkt_end(pkt_end),
    .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // per-unit source streams and gating
  logic [63:0] src_d [N][$];
  bit          src_l [N][$];
  bit          gate  [N];
  logic [1:0]  exp_q [$];   // expected grant order at packet ends

  // behavioural model: phase 0 = waiting, 1 = header word, 2 = moving data
  int          m_phase, m_unit, m_prev, m_words;
  logic [15:0] m_pkts;

  int n_checks, n_errors, n_wr, n_cyc;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int rr_model();
    for (int k = 1; k <= N; k++) begin
      int u;
      u = (m_prev + k) % N;
      if (unit_valid[u]) return u;
    end
    return -1;
  endfunction

  function automatic bit pending();
    for (int u = 0; u < N; u++) if (src_d[u].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_unit = 0; m_prev = N - 1; m_words = 0; m_pkts = '0;
    for (int u = 0; u < N; u++) begin
      src_d[u].delete();
      src_l[u].delete();
    end
    exp_q.delete();
  endtask

  task automatic add_pkt(input int u, input int len, input bit with_last);
    for (int k = 0; k < len; k++) begin
      src_d[u].push_back({$urandom, $urandom});
      src_l[u].push_back(with_last && (k == len - 1));
    end
  endtask

  task automatic drive_inputs();
    for (int u = 0; u < N; u++) begin
      if (src_d[u].size() > 0) begin
        unit_valid[u]          = gate[u];
        unit_dout[64*u +: 64]  = src_d[u][0];
        unit_last[u]           = src_l[u][0];
      end else begin
        unit_valid[u]          = 1'b0;
        unit_dout[64*u +: 64]  = 64'h0;
        unit_last[u]           = 1'b0;
      end
    end
  endtask

  // One clock: drive at negedge, check at negedge+1, advance model at posedge.
  task automatic cycle();
    logic take, hdr, lastw;
    logic [63:0] ew;
    logic [N-1:0] erd;
    int pick;
    drive_inputs();
    #1;
    take  = (m_phase == 2) && unit_valid[m_unit] && !full;
    hdr   = (m_phase == 1) && !full;
    lastw = 1'b0;
    erd   = '0;
    ew    = 64'h0;
    if (take) begin
      lastw       = src_l[m_unit][0] || (m_words == MAXW - 1);
      erd[m_unit] = 1'b1;
      ew          = src_d[m_unit][0];
    end else if (hdr) begin
      ew = {8'hA5, 8'(m_unit), m_pkts, 32'h0};
    end
    check("wr_en", wr_en, take || hdr);
    check("dout", dout, ew);
    check("pkt_end", pkt_end, lastw);
    check("unit_rd_en", unit_rd_en, erd);
    check("grant_id", grant_id, m_unit);
    check("busy", busy, m_phase != 0);
    check("pkt_count", pkt_count, m_pkts);
`ifdef PKT_OUTPUT_ARBITER_HEADER_EN
    if (hdr && m_unit == 3 && m_pkts == 16'd7) check("hdr_literal", dout, 64'hA503_0007_0000_0000);
`endif
    if (lastw && exp_q.size() > 0) check("grant_order", grant_id, exp_q.pop_front());
    if (wr_en) n_wr++;
    n_cyc++;
    pick = rr_model();
    @(posedge CLK);
    if (m_phase == 0) begin
      if (en && pick >= 0) begin
        m_unit  = pick;
        m_words = 0;
`ifdef PKT_OUTPUT_ARBITER_HEADER_EN
        m_phase = 1;
`else
        m_phase = 2;
`endif
      end
    end else if (m_phase == 1) begin
      if (!full) m_phase = 2;
    end else if (take) begin
      void'(src_d[m_unit].pop_front());
      void'(src_l[m_unit].pop_front());
      m_words++;
      if (lastw) begin
        m_phase = 0;
        m_prev  = m_unit;
        m_pkts  = m_pkts + 16'd1;
      end
    end
    @(negedge CLK);
  endtask

  task automatic drain(input string tag, input int limit);
    int c;
    c = 0;
    while ((pending() || m_phase != 0) && c < limit) begin
      cycle();
      c++;
    end
    check(tag, pending() || m_phase != 0, 1'b0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_pkt_end", pkt_end, 1'b0);
    check("rst_rd_en", unit_rd_en, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_dout", dout, 64'h0);
    check("rst_grant", grant_id, 2'd0);
    check("rst_pkt_count", pkt_count, 16'd0);
    model_reset();
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    int g;
    n_checks = 0; n_errors = 0; n_wr = 0; n_cyc = 0;
    en = 1'b1; full = 1'b0; unit_dout = '0; unit_valid = '0; unit_last = '0;
    for (int u = 0; u < N; u++) gate[u] = 1'b1;
    do_reset();

    // units 0 and 2, three-word packets
    add_pkt(0, 3, 1'b1);
    add_pkt(2, 3, 1'b1);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd2);
    n_wr = 0; n_cyc = 0;
    drain("s1_drain", 50);
    check("s1_pkt_count", pkt_count, 16'd2);
`ifndef PKT_OUTPUT_ARBITER_HEADER_EN
    check("s1_cycles", n_cyc, 8);
`endif

    // all units valid, one-word packets: strict rotation, half-rate writes
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int u = 0; u < N; u++) begin
        add_pkt(u, 1, 1'b1);
        exp_q.push_back(2'(u));
      end
    n_wr = 0; n_cyc = 0;
    drain("s2_drain", 100);
`ifndef PKT_OUTPUT_ARBITER_HEADER_EN
    check("s2_writes", n_wr, 12);
    check("s2_cycles", n_cyc, 24);
`endif

    // 300 words without last: forced split at MAX_PKT_WORDS
    add_pkt(1, 299, 1'b0);
    add_pkt(1, 1, 1'b1);
    drain("s3_drain", 800);

    // full held for five cycles mid-packet
    add_pkt(0, 8, 1'b1);
    for (int i = 0; i < 20; i++) begin
      full = (i >= 4 && i < 9);
      cycle();
    end
    full = 1'b0;
    drain("s4_drain", 50);

    // en dropped mid-packet: packet completes, no new grant
    add_pkt(0, 4, 1'b1);
    add_pkt(1, 2, 1'b1);
    g = 0;
    while (!(m_phase == 2 && m_words == 2) && g < 20) begin cycle(); g++; end
    check("s5_reach", (m_phase == 2 && m_words == 2), 1'b1);
    en = 1'b0;
    g = 0;
    while (m_phase != 0 && g < 20) begin cycle(); g++; end
    repeat (6) cycle();
    check("s5_hold_busy", busy, 1'b0);
    en = 1'b1;
    drain("s5_drain", 50);

    // random traffic, gating, backpressure and enable
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        int u;
        u = $urandom_range(0, N - 1);
        if (src_d[u].size() < 20) add_pkt(u, $urandom_range(1, 6), 1'b1);
      end
      for (int u = 0; u < N; u++) gate[u] = ($urandom_range(0, 9) < 8);
      full = ($urandom_range(0, 3) == 0);
      en   = ($urandom_range(0, 9) != 0);
      cycle();
    end
    for (int u = 0; u < N; u++) gate[u] = 1'b1;
    full = 1'b0; en = 1'b1;
    drain("rand_drain", 2000);

    // reset in the middle of a packet
    add_pkt(2, 6, 1'b1);
    g = 0;
    while (!(m_phase == 2 && m_words == 3) && g < 20) begin cycle(); g++; end
    check("s6_reach", (m_phase == 2 && m_words == 3), 1'b1);
    do_reset();

    // seven packets, then unit 3 sends a two-word packet
    for (int k = 0; k < 7; k++) add_pkt(0, 1, 1'b1);
    drain("s7_drain", 100);
    check("s7_pkt_count", pkt_count, 16'd7);
    add_pkt(3, 2, 1'b1);
    exp_q.push_back(2'd3);
    drain("s8_drain", 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pkt_output_arbiter.md
PKT_OUTPUT_ARBITER -- requirements
Module: pkt_output_arbiter

Interface
REQ-001 Parameter N_UNITS, default 4, number of requesting application units (2..16).
REQ-002 Parameter MAX_PKT_WORDS, default 256, max words per output packet before forced termination.
REQ-003 CLK  input  1  single clock for all logic; the application clock domain.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  enables new grants (from app_mode); a packet in progress always completes.
REQ-006 unit_dout  input  N_UNITS*64  word from unit i at bits [64*i+63:64*i].
REQ-007 unit_valid  input  N_UNITS  unit i has a word on unit_dout.
REQ-008 unit_last  input  N_UNITS  unit i's current word ends its packet.
REQ-009 unit_rd_en  output  N_UNITS  unit i's word is consumed this cycle.
REQ-010 dout  output  64  word to the output packet FIFO.
REQ-011 wr_en  output  1  writes dout into the output packet FIFO.
REQ-012 full  input  1  output packet FIFO full; no write is issued while high.
REQ-013 pkt_end  output  1  marks the written word as the end of a packet.
REQ-014 grant_id  output  clog2(N_UNITS)  index of the granted unit.
REQ-015 busy  output  1  high outside IDLE.
REQ-016 pkt_count  output  16  packets completed, wraps 16'hFFFF->0.

Function
REQ-017 The FSM SHALL have states IDLE, HEADER (only when the macro is defined) and XFER.
REQ-018 In IDLE with en=1 and any unit_valid, the block SHALL register a round-robin winner into grant_id, starting the search at last_grant+1 mod N_UNITS, and SHALL move to HEADER or XFER on the next edge.
REQ-019 IDLE SHALL last at least one cycle per packet, giving a one-cycle arbitration bubble, and SHALL issue no writes.
REQ-020 In XFER, accept = unit_valid[grant_id] && !full; unit_rd_en[grant_id], wr_en and dout SHALL follow accept combinationally in the same cycle, with zero latency.
REQ-021 unit_rd_en SHALL be one-hot or zero, and SHALL be zero for every non-granted unit.
REQ-022 pkt_end SHALL equal accept && (unit_last[grant_id] || word_cnt == MAX_PKT_WORDS-1).
REQ-023 word_cnt SHALL clear on entry to XFER and increment on each accept.
REQ-024 When an accept has pkt_end=1, the FSM SHALL return to IDLE, set last_grant to grant_id and increment pkt_count.
REQ-025 A forced end at MAX_PKT_WORDS SHALL leave the unit's remaining words for its next grant.
REQ-026 full=1 or unit_valid low in XFER SHALL stall with no write, no state change and the grant held.
REQ-027 en falling during HEADER or XFER SHALL NOT abort the packet.
REQ-028 A unit that drops unit_valid mid-packet SHALL keep the grant indefinitely.

Reset
REQ-029 RESET SHALL asynchronously force state=IDLE, grant_id=0, last_grant=N_UNITS-1 (so unit 0 wins first), word_cnt=0 and pkt_count=0.
REQ-030 During and after reset, wr_en, pkt_end, unit_rd_en and busy SHALL be 0 and dout SHALL be 0.
REQ-031 RESET mid-packet SHALL drop the packet without emitting pkt_end.

Configuration
REQ-032 Macro PKT_OUTPUT_ARBITER_HEADER_EN: when defined, HEADER SHALL write one word {8'hA5, 8'(grant_id), pkt_count[15:0], 32'h0} when !full, with pkt_end=0 and no unit_rd_en, then move to XFER.
REQ-033 A full stall in HEADER SHALL hold the state.
REQ-034 Without the macro, HEADER SHALL NOT exist, IDLE SHALL go directly to XFER, and output words SHALL be unit words only.

Structure
REQ-035 Shared package arb_pkg SHALL hold the state enum, the header magic 8'hA5 and the parameter defaults.
REQ-036 Sub-module rr_pick SHALL implement the combinational round-robin priority picker (request vector, last index in, winner index and found flag out).
REQ-037 The FSM, counters and datapath mux SHALL stay in pkt_output_arbiter.

Verification
REQ-038 Units 0 and 2 valid, 3-word packets, full=0 -> grants 0 then 2; each packet takes 1 IDLE cycle plus 3 writes; pkt_count=2.
REQ-039 All 4 units continuously valid, 1-word packets -> grant order 0,1,2,3,0; wr_en has a 50% duty cycle.
REQ-040 Unit 1 sends 300 words without last, MAX_PKT_WORDS=256 -> pkt_end on word 256; the next grant goes to unit 1 (only requester) and ends the packet on word 300.
REQ-041 full held high for 5 cycles mid-packet -> no wr_en and no unit_rd_en during the hold; the data word is unchanged and accepted the cycle full falls.
REQ-042 en=0 asserted at word 2 of a 4-word packet -> the packet completes, then IDLE holds with valid requests pending.
REQ-043 With the macro, unit 3 sends a 2-word packet when pkt_count=7 -> writes A5_03_0007_00000000, then the 2 data words, pkt_end on the last; RESET mid-XFER -> outputs 0 immediately.
